// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions: opcode/funct encodings, data-memory geometry and the
// instruction classifier used by the ALU, decode and memory stages.
package mem_stage_pkg;

  localparam int unsigned MEM_DEPTH = 1024;
  localparam int unsigned ADDR_W    = 10;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;

  typedef enum logic [2:0] {
    InsNop,
    InsRtype,
    InsAddi,
    InsLw,
    InsSw
  } ins_e;

  function automatic ins_e decode_ins(input logic [31:0] ir);
    ins_e ins;
    ins = InsNop;
    case (ir[31:26])
      OP_RTYPE: if (ir[5:0] == FN_ADD || ir[5:0] == FN_SUB) ins = InsRtype;
      OP_ADDI:  ins = InsAddi;
      OP_LW:    ins = InsLw;
      OP_SW:    ins = InsSw;
      default:  ins = InsNop;
    endcase
    return ins;
  endfunction

endpackage

// File: rtl/data_ram.sv
// Word-wide data memory: one synchronous write port, one asynchronous read port, no reset.
module data_ram #(
  parameter int unsigned Depth = 1024,
  parameter int unsigned AddrW = 10
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: performs lw/sw against data_ram and registers the result,
// destination register and writeback enable for the writeback stage.
module mem_stage #(
  parameter int unsigned MEM_DEPTH = mem_stage_pkg::MEM_DEPTH
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] IR,
  input  logic [31:0] saida,
  input  logic [9:0]  mem_dest,
  input  logic        in_valid,
  input  logic        stall,
  output logic [31:0] m_IR,
  output logic [31:0] saidaULA_mm,
  output logic [4:0]  wb_reg,
  output logic        wb_en
);

  import mem_stage_pkg::*;

  logic [31:0] ir_q, ir_d;
  logic [31:0] res_q, res_d;
  logic [4:0]  reg_q, reg_d;
  logic        en_q, en_d;
  logic        mem_we;
  logic [31:0] ld_data;
  ins_e        ins;

  assign ins = decode_ins(IR);

  always_comb begin
    ir_d   = ir_q;
    res_d  = res_q;
    reg_d  = reg_q;
    en_d   = en_q;
    mem_we = 1'b0;
    if (!stall) begin
      ir_d  = '0;
      res_d = '0;
      reg_d = '0;
      en_d  = 1'b0;
      if (in_valid) begin
        ir_d = IR;
        case (ins)
          InsRtype: begin
            res_d = saida;
            reg_d = IR[15:11];
            en_d  = |IR[15:11];
          end
          InsAddi: begin
            res_d = saida;
            reg_d = IR[20:16];
            en_d  = |IR[20:16];
          end
          InsLw: begin
            res_d = ld_data;
            reg_d = mem_dest[4:0];
            en_d  = |mem_dest[4:0];
          end
          InsSw: begin
            res_d  = saida;
            // The RAM has no reset, so a store seen while reset is held must be blocked here.
            mem_we = reset;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ir_q  <= '0;
      res_q <= '0;
      reg_q <= '0;
      en_q  <= 1'b0;
    end else begin
      ir_q  <= ir_d;
      res_q <= res_d;
      reg_q <= reg_d;
      en_q  <= en_d;
    end
  end

  data_ram #(
    .Depth (MEM_DEPTH),
    .AddrW (ADDR_W)
  ) u_data_ram (
    .clk_i   (clock),
    .we_i    (mem_we),
    .waddr_i (mem_dest[ADDR_W-1:0]),
    .wdata_i (saida),
    .raddr_i (saida[ADDR_W-1:0]),
    .rdata_o (ld_data)
  );

  assign m_IR        = ir_q;
  assign saidaULA_mm = res_q;
  assign wb_reg      = reg_q;
  assign wb_en       = en_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, hand-written stall/reset
// sequences and randomized traffic checked against an instruction-level reference model.
module tb_mem_stage;

  localparam logic [31:0] SW_IR = 32'hAC00_0000;
  localparam logic [31:0] LW_IR = 32'h8C00_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] IR = '0;
  logic [31:0] saida = '0;
  logic [9:0]  mem_dest = '0;
  logic        in_valid = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] m_IR;
  logic [31:0] saidaULA_mm;
  logic [4:0]  wb_reg;
  logic        wb_en;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [31:0] m_mem [1024];
  logic [31:0] e_ir  = '0;
  logic [31:0] e_res = '0;
  logic [4:0]  e_reg = '0;
  logic        e_en  = 1'b0;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] sd;
    logic [9:0]  md;
    logic        v;
    logic        st;
    logic [31:0] xir;
    logic [31:0] xres;
    logic [4:0]  xreg;
    logic        xen;
  } vec_t;

  mem_stage dut (
    .clock       (clock),
    .reset       (reset),
    .IR          (IR),
    .saida       (saida),
    .mem_dest    (mem_dest),
    .in_valid    (in_valid),
    .stall       (stall),
    .m_IR        (m_IR),
    .saidaULA_mm (saidaULA_mm),
    .wb_reg      (wb_reg),
    .wb_en       (wb_en)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] xir, input logic [31:0] xres,
                           input logic [4:0] xreg, input logic xen);
    check({tag, ".m_IR"}, m_IR, xir);
    check({tag, ".saidaULA_mm"}, saidaULA_mm, xres);
    check({tag, ".wb_reg"}, {27'd0, wb_reg}, {27'd0, xreg});
    check({tag, ".wb_en"}, {31'd0, wb_en}, {31'd0, xen});
  endtask

  task automatic model_clear();
    e_ir  = '0;
    e_res = '0;
    e_reg = '0;
    e_en  = 1'b0;
  endtask

  // Instruction-level behaviour at a rising edge, from the currently applied inputs.
  task automatic model_edge();
    logic [5:0] op, fn;
    if (!reset) begin
      model_clear();
    end else if (!stall) begin
      if (!in_valid) begin
        model_clear();
      end else begin
        op   = IR[31:26];
        fn   = IR[5:0];
        e_ir = IR;
        if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22)) begin
          e_res = saida;
          e_reg = IR[15:11];
          e_en  = (IR[15:11] != 5'd0);
        end else if (op == 6'h08) begin
          e_res = saida;
          e_reg = IR[20:16];
          e_en  = (IR[20:16] != 5'd0);
        end else if (op == 6'h23) begin
          e_res = m_mem[int'(saida % 32'd1024)];
          e_reg = mem_dest[4:0];
          e_en  = (mem_dest[4:0] != 5'd0);
        end else if (op == 6'h2B) begin
          m_mem[int'(mem_dest) % 1024] = saida;
          e_res = saida;
          e_reg = '0;
          e_en  = 1'b0;
        end else begin
          e_res = '0;
          e_reg = '0;
          e_en  = 1'b0;
        end
      end
    end
  endtask

  task automatic drive(input logic [31:0] ir, input logic [31:0] sd, input logic [9:0] md,
                       input logic v, input logic st);
    IR       = ir;
    saida    = sd;
    mem_dest = md;
    in_valid = v;
    stall    = st;
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  initial begin
    vec_t vecs[$];
    logic [31:0] rir, rsd;
    logic [9:0]  rmd;
    logic [4:0]  rs, rt, rd;

    vecs.push_back('{SW_IR, 32'hDEAD_BEEF, 10'd5, 1'b1, 1'b0,
                     SW_IR, 32'hDEAD_BEEF, 5'd0, 1'b0});
    vecs.push_back('{LW_IR, 32'd5, 10'd8, 1'b1, 1'b0,
                     LW_IR, 32'hDEAD_BEEF, 5'd8, 1'b1});
    vecs.push_back('{32'h2009_0007, 32'd7, 10'd0, 1'b1, 1'b0,
                     32'h2009_0007, 32'd7, 5'd9, 1'b1});
    vecs.push_back('{32'h0000_0020, 32'h0000_1234, 10'd0, 1'b1, 1'b0,
                     32'h0000_0020, 32'h0000_1234, 5'd0, 1'b0});
    vecs.push_back('{LW_IR, 32'h0000_0405, 10'd3, 1'b1, 1'b0,
                     LW_IR, 32'hDEAD_BEEF, 5'd3, 1'b1});
    vecs.push_back('{32'h0000_1822, 32'hFFFF_FFFF, 10'd0, 1'b1, 1'b0,
                     32'h0000_1822, 32'hFFFF_FFFF, 5'd3, 1'b1});
    vecs.push_back('{32'h0000_0021, 32'd55, 10'd4, 1'b1, 1'b0,
                     32'h0000_0021, 32'd0, 5'd0, 1'b0});
    vecs.push_back('{32'hFC00_0000, 32'd99, 10'd4, 1'b1, 1'b0,
                     32'hFC00_0000, 32'd0, 5'd0, 1'b0});
    vecs.push_back('{LW_IR, 32'd5, 10'h020, 1'b1, 1'b0,
                     LW_IR, 32'hDEAD_BEEF, 5'd0, 1'b0});
    vecs.push_back('{SW_IR, 32'h5555_5555, 10'd5, 1'b0, 1'b0,
                     32'd0, 32'd0, 5'd0, 1'b0});
    vecs.push_back('{LW_IR, 32'd5, 10'd1, 1'b1, 1'b0,
                     LW_IR, 32'hDEAD_BEEF, 5'd1, 1'b1});

    // Reset state
    drive(SW_IR, 32'h1, 10'd5, 1'b1, 1'b0);
    repeat (2) tick();
    check_out("reset", 32'd0, 32'd0, 5'd0, 1'b0);
    @(negedge clock);
    reset = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].ir, vecs[i].sd, vecs[i].md, vecs[i].v, vecs[i].st);
      tick();
      check_out($sformatf("vec%0d", i), vecs[i].xir, vecs[i].xres, vecs[i].xreg, vecs[i].xen);
    end

    // Stall holds registers and blocks the presented store
    drive(32'h2009_0007, 32'd7, 10'd0, 1'b1, 1'b0);
    tick();
    check_out("addi", 32'h2009_0007, 32'd7, 5'd9, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(SW_IR, 32'h1111_1111, 10'd5, 1'b1, 1'b1);
      tick();
      check_out($sformatf("stall%0d", i), 32'h2009_0007, 32'd7, 5'd9, 1'b1);
    end
    drive(SW_IR, 32'h1111_1111, 10'd5, 1'b0, 1'b1);
    tick();
    check_out("stall_novalid", 32'h2009_0007, 32'd7, 5'd9, 1'b1);
    drive(SW_IR, 32'h1111_1111, 10'd5, 1'b0, 1'b0);
    tick();
    check_out("bubble", 32'd0, 32'd0, 5'd0, 1'b0);
    drive(LW_IR, 32'd5, 10'd8, 1'b1, 1'b0);
    tick();
    check_out("lw_after_stall", LW_IR, 32'hDEAD_BEEF, 5'd8, 1'b1);

    // Asynchronous reset mid-cycle; a store on the reset edge must be dropped
    #4;
    reset = 1'b0;
    model_clear();
    #1;
    check_out("rst_async", 32'd0, 32'd0, 5'd0, 1'b0);
    drive(SW_IR, 32'h2222_2222, 10'd5, 1'b1, 1'b0);
    tick();
    check_out("rst_edge", 32'd0, 32'd0, 5'd0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    drive(LW_IR, 32'd5, 10'd9, 1'b1, 1'b0);
    tick();
    check_out("lw_after_rst", LW_IR, 32'hDEAD_BEEF, 5'd9, 1'b1);

    // Fill a small address window so random loads read defined data
    for (int a = 0; a < 16; a++) begin
      drive(SW_IR, $urandom, 10'(a), 1'b1, 1'b0);
      tick();
      check_out($sformatf("fill%0d", a), e_ir, e_res, e_reg, e_en);
    end

    for (int n = 0; n < 400; n++) begin
      rs  = 5'($urandom);
      rt  = 5'($urandom);
      rd  = 5'($urandom);
      rsd = $urandom;
      rmd = 10'($urandom);
      case ($urandom_range(0, 5))
        0: rir = {6'h00, rs, rt, rd, 5'd0, 6'h20};
        1: rir = {6'h00, rs, rt, rd, 5'd0, 6'h22};
        2: rir = {6'h08, rs, rt, 16'($urandom)};
        3: begin
          rir = {6'h23, rs, rt, 16'($urandom)};
          rsd = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 15));
        end
        4: begin
          rir = {6'h2B, rs, rt, 16'($urandom)};
          rmd = 10'($urandom_range(0, 15));
        end
        default: begin
          rir = $urandom;
          if (rir[31:26] == 6'h23) rir[31:26] = 6'h3F;
        end
      endcase
      drive(rir, rsd, rmd, $urandom_range(0, 4) != 0, $urandom_range(0, 4) == 0);
      tick();
      check_out($sformatf("rand%0d", n), e_ir, e_res, e_reg, e_en);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter MEM_DEPTH, default 1024, data-memory depth in 32-bit words; addressing uses ADDR_W = 10 bits.
REQ-002 clock  input  1  single rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-004 IR  input  32  instruction leaving the ALU stage.
REQ-005 saida  input  32  ALU result: R-type/addi result, lw address in [9:0], sw store data.
REQ-006 mem_dest  input  10  lw destination register in [4:0]; sw word address.
REQ-007 in_valid  input  1  IR/saida/mem_dest carry a real instruction this cycle.
REQ-008 stall  input  1  hold the stage; no capture, no memory write.
REQ-009 m_IR  output  32  instruction held in this stage; feeds the ALU stage's m_IR.
REQ-010 saidaULA_mm  output  32  result held in this stage: ALU result or loaded word; feeds the ALU stage forwarding path.
REQ-011 wb_reg  output  5  destination register for writeback.
REQ-012 wb_en  output  1  register-file write enable for the held instruction.

Function
REQ-013 Decode SHALL use opcode IR[31:26] and, for R-type, funct IR[5:0]: R-type 000000 with add 100000 or sub 100010; addi 001000; lw 100011; sw 101011; any other encoding is a NOP.
REQ-014 On a rising edge with reset=1, stall=0 and in_valid=1, the stage SHALL capture m_IR <= IR.
REQ-015 On a capture of add/sub: saidaULA_mm <= saida; wb_reg <= IR[15:11]; wb_en <= (IR[15:11] != 0).
REQ-016 On a capture of addi: saidaULA_mm <= saida; wb_reg <= IR[20:16]; wb_en <= (IR[20:16] != 0).
REQ-017 On a capture of lw: saidaULA_mm <= mem[saida[9:0]] (value before any same-edge write); wb_reg <= mem_dest[4:0]; wb_en <= (mem_dest[4:0] != 0).
REQ-018 On a capture of sw: mem[mem_dest] <= saida; saidaULA_mm <= saida; wb_reg <= 0; wb_en <= 0.
REQ-019 On a capture of a NOP: saidaULA_mm <= 0; wb_reg <= 0; wb_en <= 0.
REQ-020 Latency SHALL be exactly one cycle from capture edge to valid outputs; a lw issued the cycle after a sw to the same address SHALL return the stored word.
REQ-021 With stall=0 and in_valid=0, the stage SHALL insert a bubble: m_IR, saidaULA_mm and wb_reg <= 0; wb_en <= 0; no memory write.
REQ-022 With stall=1, all stage registers and memory SHALL hold, regardless of in_valid.
REQ-023 Memory addresses SHALL wrap modulo MEM_DEPTH; address bits above bit 9 are ignored.
REQ-024 Outputs SHALL be driven from registers only; there is no combinational path from inputs to outputs.

Reset
REQ-025 Assertion of reset (0) SHALL immediately clear m_IR, saidaULA_mm, wb_reg and wb_en to 0, independent of clock.
REQ-026 A sw presented on the same edge at which reset is low SHALL NOT write memory.
REQ-027 Data memory contents SHALL NOT be affected by reset.
REQ-028 After reset deassertion, the first capture SHALL occur on the first rising edge with stall=0.

Structure
REQ-029 Opcode/funct constants (OP_RTYPE, OP_ADDI, OP_LW, OP_SW, FN_ADD, FN_SUB) and MEM_DEPTH/ADDR_W SHALL live in the shared pipeline package, shared with the ALU and decode stages.
REQ-030 The memory array SHALL be a sub-module data_ram: 32-bit, MEM_DEPTH words, one synchronous write port, one read port, no reset.

Verification
REQ-031 The bench SHALL cover: sw with mem_dest=5, saida=0xDEADBEEF, then lw with saida=5, mem_dest=8 -> next cycle saidaULA_mm=0xDEADBEEF, wb_reg=8, wb_en=1.
REQ-032 The bench SHALL cover: addi IR=0x20090007 (rt=9), saida=7 -> saidaULA_mm=7, wb_reg=9, wb_en=1, m_IR=0x20090007.
REQ-033 The bench SHALL cover: add with rd=0 -> wb_en=0; lw with saida=0x405 reads word 5 (wrap).
REQ-034 The bench SHALL cover: stall=1 for 3 cycles with a sw presented -> outputs unchanged and memory word unchanged; then in_valid=0 -> bubble with all outputs 0.
REQ-035 The bench SHALL cover: reset pulled low mid-cycle while wb_en=1 -> all outputs 0 before the next edge; a sw on that edge is not written; previously stored words survive.
